// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared CPU types for the HI/LO multiply/divide unit.
//   word_t  : 32-bit architectural word
//   op_t    : HI/LO operation code (unlisted encodings act as no-ops)
//   state_t : controller state (IDLE, MUL, DIV, FIX)
package hilo_muldiv_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  localparam int unsigned DIV_STEPS = 32;

  // Two's-complement magnitude; 32'h8000_0000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic word_t abs_word(input word_t x, input logic is_signed);
    return (is_signed && x[31]) ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
//   start     : load dividend/divisor, clear remainder and counter
//   step      : perform one iteration (ignored once 32 steps are done)
//   clear     : abort; zero all divider state
//   quotient  : quotient register
//   remainder : partial/final remainder
//   done      : high during the step that produces the last quotient bit
module div_iter
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  start,
  input  logic  step,
  input  logic  clear,
  input  word_t dividend,
  input  word_t divisor,
  output word_t quotient,
  output word_t remainder,
  output logic  done
);

  logic [5:0]  cnt_q, cnt_d;
  word_t       rem_q, rem_d;
  word_t       quo_q, quo_d;
  word_t       dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] trial;

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);
  localparam logic [5:0] ALL_STEPS = 6'(DIV_STEPS);

  // The dividend shifts out of the quotient register MSB-first while
  // quotient bits shift in at the bottom.
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (clear) begin
      cnt_d = '0;
      rem_d = '0;
      quo_d = '0;
      dvs_d = '0;
    end else if (start) begin
      cnt_d = '0;
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step && (cnt_q != ALL_STEPS)) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = step && (cnt_q == LAST_STEP);

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller with architectural HI and LO registers.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/req_ready  : op handshake (ready only in IDLE)
//   op, vs, vt           : operation and rs/rt operand values
//   flush                : abort in-flight op, drop any request this cycle
//   busy                 : MUL/DIV in flight
//   hi, lo               : architectural HI/LO values
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  req_valid,
  output logic  req_ready,
  input  op_t   op,
  input  word_t vs,
  input  word_t vt,
  input  logic  flush,
  output logic  busy,
  output word_t hi,
  output word_t lo
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  word_t       a_q, a_d;
  word_t       b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  mul_cnt_q, mul_cnt_d;

  logic        accept;
  logic        is_div_op;
  logic        div_start;
  logic        div_step;
  logic        div_done;
  word_t       div_quo;
  word_t       div_rem;
  word_t       q_fix;
  word_t       r_fix;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  assign accept    = req_valid && (state_q == IDLE) && !flush;
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign div_start = accept && is_div_op;
  assign div_step  = (state_q == DIV) && !flush;

  div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .clear     (flush),
    .dividend  (abs_word(vs, op == OP_DIV)),
    .divisor   (abs_word(vt, op == OP_DIV)),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign prod_s = 64'($signed(a_q) * $signed(b_q));
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod   = sgn_q ? prod_s : prod_u;

  assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? word_t'(-div_quo) : div_quo;
  assign r_fix = (sgn_q && a_q[31]) ? word_t'(-div_rem) : div_rem;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d   = MUL;
              a_d       = vs;
              b_d       = vt;
              sgn_d     = (op == OP_MULT);
              mul_cnt_d = '0;
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              a_d     = vs;
              b_d     = vt;
              sgn_d   = (op == OP_DIV);
            end
            OP_MTHI: hi_d = vs;
            OP_MTLO: lo_d = vs;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mul_cnt_q == MUL_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = IDLE;
        end else begin
          mul_cnt_d = mul_cnt_q + 3'd1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else if (div_done) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          // Divide by zero bypasses sign fix-up so HI keeps the raw dividend.
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign req_ready = !busy;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed testbench for hilo_muldiv_ctrl: table of single ops plus
// hand-written flush and reset sequences.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int unsigned MC = 3;

  logic  clk = 1'b0;
  logic  resetn;
  logic  req_valid;
  logic  req_ready;
  op_t   op;
  word_t vs;
  word_t vt;
  logic  flush;
  logic  busy;
  word_t hi;
  word_t lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    op_t         op;
    word_t       vs;
    word_t       vt;
    word_t       hi;
    word_t       lo;
    int unsigned cyc;
  } vec_t;

  vec_t vecs[12];

  hilo_muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .vs        (vs),
    .vt        (vt),
    .flush     (flush),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Offer one op at a negedge; after acceptance scramble operands so any
  // failure to latch them shows up in the result.
  task automatic start_op(input op_t o, input word_t a, input word_t b);
    @(negedge clk);
    req_valid = 1'b1;
    op        = o;
    vs        = a;
    vt        = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op        = OP_NOP;
    vs        = $urandom;
    vt        = $urandom;
  endtask

  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int unsigned n;
    word_t       op7;

    vecs[0]  = '{OP_MTHI,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, 0};
    vecs[1]  = '{OP_MTLO,  32'h9ABC_DEF0, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[2]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
    vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, MC};
    vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[6]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33};
    vecs[7]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
    vecs[8]  = '{op_t'(3'd7), 32'hDEAD_BEEF, 32'h1,      32'h0,         32'h8000_0000, 0};
    vecs[9]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MC};
    vecs[10] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};

    resetn    = 1'b0;
    req_valid = 1'b0;
    op        = OP_NOP;
    vs        = '0;
    vt        = '0;
    flush     = 1'b0;
    op7       = '0;
    #3;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].op, vecs[i].vs, vecs[i].vt);
      wait_idle(n);
      check($sformatf("vec%0d cycles", i), n, vecs[i].cyc);
      check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d ready", i), {31'b0, req_ready}, 32'h1);
    end

    // Flush on cycle 10 of a DIV, then MULT on the very next cycle.
    start_op(OP_MTHI, 32'hA5A5_0001, 32'h0);
    start_op(OP_MTLO, 32'h5A5A_0002, 32'h0);
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush div busy", {31'b0, busy}, 32'h0);
    check("flush div ready", {31'b0, req_ready}, 32'h1);
    check("flush div hi", hi, 32'hA5A5_0001);
    check("flush div lo", lo, 32'h5A5A_0002);
    start_op(OP_MULT, 32'd3, 32'd5);
    wait_idle(n);
    check("post flush mult cycles", n, MC);
    check("post flush mult hi", hi, 32'h0);
    check("post flush mult lo", lo, 32'd15);

    // Flush coinciding with the FIX write cycle.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("fix busy", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush fix busy", {31'b0, busy}, 32'h0);
    check("flush fix hi", hi, 32'h0);
    check("flush fix lo", lo, 32'd15);

    // Flush coinciding with the last MUL cycle.
    start_op(OP_MULTU, 32'd6, 32'd7);
    repeat (MC - 1) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush mul busy", {31'b0, busy}, 32'h0);
    check("flush mul hi", hi, 32'h0);
    check("flush mul lo", lo, 32'd15);

    // Flush together with MTHI in IDLE drops the write.
    @(negedge clk);
    req_valid = 1'b1;
    op        = OP_MTHI;
    vs        = 32'hDEAD_0001;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op        = OP_NOP;
    flush     = 1'b0;
    check("flush mthi hi", hi, 32'h0);
    check("flush mthi busy", {31'b0, busy}, 32'h0);

    // Asynchronous reset in the middle of a DIV.
    start_op(OP_MTHI, 32'h1111_2222, 32'h0);
    start_op(OP_DIVU, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset hi", hi, 32'h0);
    check("async reset lo", lo, 32'h0);
    check("async reset busy", {31'b0, busy}, 32'h0);
    check("async reset ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post reset hi", hi, 32'h0);
    check("post reset lo", lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
